// File: rtl/mult_seq_core.sv
// Iterative signed radix-2 shift-add multiplier with operand parity checking.
// Handshake: req/ack to capture operands, then a result_rdy pulse.
module mult_seq_core #(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     arg_a,
  input  logic                  arg_a_parity,
  input  logic [DATA_W-1:0]     arg_b,
  input  logic                  arg_b_parity,
  input  logic                  req,
  output logic                  ack,
  output logic [2*DATA_W-1:0]   result,
  output logic                  result_parity,
  output logic                  result_rdy,
  output logic                  arg_parity_error
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, ACK, CALC, DONE} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [2*DATA_W-1:0] mcand;
  logic [DATA_W-1:0]   mplier;
  logic [2*DATA_W-1:0] acc;
  logic                neg;
  logic                perr;

  logic [DATA_W-1:0]   mag_a, mag_b;
  logic [2*DATA_W-1:0] prod;

  // Magnitude of the most negative value still fits unsigned in DATA_W bits.
  assign mag_a = arg_a[DATA_W-1] ? (~arg_a + DATA_W'(1)) : arg_a;
  assign mag_b = arg_b[DATA_W-1] ? (~arg_b + DATA_W'(1)) : arg_b;
  assign prod  = neg ? (~acc + (2*DATA_W)'(1)) : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      mcand            <= '0;
      mplier           <= '0;
      acc              <= '0;
      neg              <= 1'b0;
      perr             <= 1'b0;
      ack              <= 1'b0;
      result           <= '0;
      result_parity    <= 1'b0;
      result_rdy       <= 1'b0;
      arg_parity_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          result_rdy <= 1'b0;
          if (req) begin
            ack    <= 1'b1;
            mcand  <= {{DATA_W{1'b0}}, mag_a};
            mplier <= mag_b;
            acc    <= '0;
            neg    <= arg_a[DATA_W-1] ^ arg_b[DATA_W-1];
            perr   <= (arg_a_parity != ^arg_a) | (arg_b_parity != ^arg_b);
            state  <= ACK;
          end
        end
        ACK: begin
          ack   <= 1'b0;
          cnt   <= '0;
          state <= perr ? DONE : CALC;
        end
        CALC: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(DATA_W-1)) state <= DONE;
        end
        DONE: begin
          result_rdy       <= 1'b1;
          arg_parity_error <= perr;
          result           <= perr ? '0 : prod;
          result_parity    <= perr ? 1'b0 : ^prod;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_core.sv
// Bench for mult_seq_core: vector table driven through a scoreboard queue,
// plus reset-abort and back-to-back request sequences.
module tb_mult_seq_core;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   arg_a, arg_b;
  logic           arg_a_parity, arg_b_parity, req;
  logic           ack, result_parity, result_rdy, arg_parity_error;
  logic [2*W-1:0] result;

  mult_seq_core #(.DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .arg_a(arg_a), .arg_a_parity(arg_a_parity),
    .arg_b(arg_b), .arg_b_parity(arg_b_parity),
    .req(req), .ack(ack),
    .result(result), .result_parity(result_parity),
    .result_rdy(result_rdy), .arg_parity_error(arg_parity_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    bit             bad_a;
    logic [W-1:0]   b;
    bit             bad_b;
    logic [2*W-1:0] res;
    bit             err;
  } vec_t;

  typedef struct {
    logic [2*W-1:0] res;
    bit             err;
    int             cyc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[12];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   rdy_cnt = 0;
  bit   prev_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard consumer: every result_rdy pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && result_rdy) begin
      rdy_cnt++;
      chk("rdy_one_cycle", {63'd0, prev_rdy}, 64'd0);
      if (sb.size() == 0) begin
        chk("unexpected_rdy", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", {32'd0, result}, {32'd0, e.res});
        chk("result_parity", {63'd0, result_parity}, {63'd0, ^e.res});
        chk("arg_parity_error", {63'd0, arg_parity_error}, {63'd0, e.err});
        chk("latency", 64'(cyc), 64'(e.cyc));
      end
    end
    prev_rdy = rst_n && result_rdy;
  end

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ack) begin ok = 1'b1; break; end
    end
    if (!ok) chk("ack_timeout", 64'd1, 64'd0);
  endtask

  task automatic drive(input logic [W-1:0] a, input bit bad_a,
                       input logic [W-1:0] b, input bit bad_b);
    @(negedge clk);
    arg_a = a; arg_a_parity = (^a) ^ bad_a;
    arg_b = b; arg_b_parity = (^b) ^ bad_b;
    req = 1'b1;
  endtask

  task automatic push(input logic [2*W-1:0] res, input bit err);
    exp_t e;
    e.res = res; e.err = err;
    e.cyc = cyc + (err ? 2 : W + 2);
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    bit ok;
    drive(v.a, v.bad_a, v.b, v.bad_b);
    wait_ack(ok);
    if (ok) push(v.res, v.err);
    // scramble operands after capture; they must not affect the result
    arg_a = ~v.a; arg_b = v.b ^ 16'h5A5A;
    req = 1'b0;
    @(negedge clk);
    chk("ack_pulse_width", {63'd0, ack}, 64'd0);
    drain();
  endtask

  initial begin
    bit ok;
    int e0, rc;
    vecs[0]  = '{16'h0003, 0, 16'h0005, 0, 32'h0000000F, 0};
    vecs[1]  = '{16'h8000, 0, 16'h8000, 0, 32'h40000000, 0};
    vecs[2]  = '{16'hFFFF, 0, 16'h0002, 0, 32'hFFFFFFFE, 0};
    vecs[3]  = '{16'h0003, 1, 16'h0005, 0, 32'h00000000, 1};
    vecs[4]  = '{16'h0007, 0, 16'h0007, 0, 32'h00000031, 0};
    vecs[5]  = '{16'h7FFF, 0, 16'h8000, 0, 32'hC0008000, 0};
    vecs[6]  = '{16'h7FFF, 0, 16'h7FFF, 0, 32'h3FFF0001, 0};
    vecs[7]  = '{16'hFFFD, 0, 16'h0005, 0, 32'hFFFFFFF1, 0};
    vecs[8]  = '{16'h0000, 0, 16'h1234, 0, 32'h00000000, 0};
    vecs[9]  = '{16'h0003, 0, 16'h0005, 1, 32'h00000000, 1};
    vecs[10] = '{16'h8000, 0, 16'h0001, 0, 32'hFFFF8000, 0};
    vecs[11] = '{16'h0123, 0, 16'hFFFF, 0, 32'hFFFFFEDD, 0};

    rst_n = 1'b0; req = 1'b0;
    arg_a = '0; arg_b = '0; arg_a_parity = 1'b0; arg_b_parity = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack", {63'd0, ack}, 64'd0);
    chk("rst_result", {32'd0, result}, 64'd0);
    chk("rst_result_parity", {63'd0, result_parity}, 64'd0);
    chk("rst_result_rdy", {63'd0, result_rdy}, 64'd0);
    chk("rst_arg_parity_error", {63'd0, arg_parity_error}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset five cycles into CALC: outputs clear at once, no result for the aborted op.
    drive(16'h0003, 0, 16'h0005, 0);
    wait_ack(ok);
    req = 1'b0;
    repeat (6) @(negedge clk);
    rc = rdy_cnt;
    rst_n = 1'b0;
    #1;
    chk("abort_ack", {63'd0, ack}, 64'd0);
    chk("abort_result", {32'd0, result}, 64'd0);
    chk("abort_result_parity", {63'd0, result_parity}, 64'd0);
    chk("abort_result_rdy", {63'd0, result_rdy}, 64'd0);
    chk("abort_arg_parity_error", {63'd0, arg_parity_error}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("abort_no_rdy", 64'(rdy_cnt), 64'(rc));
    run_vec('{16'h0007, 0, 16'h0007, 0, 32'h00000031, 0});

    // req held through busy period with new operands: taken as next transaction.
    drive(16'h0003, 0, 16'h0005, 0);
    wait_ack(ok);
    if (ok) push(32'h0000000F, 0);
    e0 = cyc;
    arg_a = 16'd100;  arg_a_parity = ^arg_a;
    arg_b = 16'hFFF9; arg_b_parity = ^arg_b;
    wait_ack(ok);
    if (ok) push(32'hFFFFFD44, 0);
    chk("b2b_accept_cycle", 64'(cyc), 64'(e0 + W + 3));
    req = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
